// File: rtl/roulette_pkg.sv
// Shared key codes and collector state encoding for the roulette bet-entry path.
package roulette_pkg;

    localparam logic [3:0] KEY_BKSP = 4'd10;
    localparam logic [3:0] KEY_CLR  = 4'd11;
    localparam logic [3:0] KEY_OK   = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        READY,
        DONE
    } state_t;

endpackage

// File: rtl/pick_mask_gen.sv
// Combinational one-hot-per-number mask of every number held in the pick slots.
module pick_mask_gen #(
    parameter int MAX_PICKS = 4,
    parameter int NUM_MAX   = 8
) (
    input  logic [MAX_PICKS*4-1:0] slots_i,
    output logic [NUM_MAX-1:0]     mask_o
);

    // Empty slots hold 0, which never matches a number key, so they drop out.
    always_comb begin
        mask_o = '0;
        for (int i = 0; i < MAX_PICKS; i++) begin
            for (int n = 0; n < NUM_MAX; n++) begin
                if (slots_i[4*i +: 4] == 4'(n + 1)) begin
                    mask_o[n] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bet_pick_collector.sv
// Keypad-driven roulette pick collector: gathers up to MAX_PICKS numbers, supports
// backspace/clear-all/confirm, and exposes the picks, their mask and status as registers.
import roulette_pkg::*;

module bet_pick_collector #(
    parameter int MAX_PICKS = 4,
    parameter int NUM_MIN   = 1,
    parameter int NUM_MAX   = 8,
    parameter int ALLOW_DUP = 0,
    localparam int CW       = $clog2(MAX_PICKS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   key_valid,
    input  logic [3:0]             key_value,
    input  logic [CW-1:0]          pick_req,
    output logic [MAX_PICKS*4-1:0] picks,
    output logic [CW-1:0]          fill_count,
    output logic [NUM_MAX-1:0]     pick_mask,
    output logic                   full,
    output logic                   confirmed,
    output logic                   reject
);

    localparam logic [CW-1:0] MAXP = CW'(MAX_PICKS);
    localparam logic [3:0]    KMIN = 4'(NUM_MIN);
    localparam logic [3:0]    KMAX = 4'(NUM_MAX);

    state_t                 state_q, state_d;
    logic [MAX_PICKS*4-1:0] picks_q, picks_d;
    logic [CW-1:0]          fill_q, fill_d;
    logic [CW-1:0]          target_q, target_d;
    logic [NUM_MAX-1:0]     mask_q, mask_d;
    logic                   full_q, full_d;
    logic                   conf_q, conf_d;
    logic                   rej_q, rej_d;
    logic                   en_prev_q;

    logic [CW-1:0]          sat_target;
    logic                   in_range;
    logic                   dup;

    // Mask follows the next slot contents so it lands in the same cycle as the slots.
    pick_mask_gen #(
        .MAX_PICKS (MAX_PICKS),
        .NUM_MAX   (NUM_MAX)
    ) u_mask (
        .slots_i (picks_d),
        .mask_o  (mask_d)
    );

    always_comb begin
        state_d  = state_q;
        picks_d  = picks_q;
        fill_d   = fill_q;
        target_d = target_q;
        rej_d    = 1'b0;

        if (pick_req == '0) begin
            sat_target = CW'(1);
        end else if (pick_req > MAXP) begin
            sat_target = MAXP;
        end else begin
            sat_target = pick_req;
        end

        in_range = (key_value >= KMIN) && (key_value <= KMAX);
        dup      = 1'b0;
        for (int n = 0; n < NUM_MAX; n++) begin
            if (key_value == 4'(n + 1) && mask_q[n]) begin
                dup = 1'b1;
            end
        end

        if (clear || !enable) begin
            state_d = IDLE;
            picks_d = '0;
            fill_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!en_prev_q) begin
                        target_d = sat_target;
                        picks_d  = '0;
                        fill_d   = '0;
                        state_d  = COLLECT;
                    end
                end
                COLLECT, READY: begin
                    if (key_valid) begin
                        if (key_value == KEY_CLR) begin
                            picks_d = '0;
                            fill_d  = '0;
                            state_d = COLLECT;
                        end else if (key_value == KEY_BKSP) begin
                            if (fill_q == '0) begin
                                rej_d = 1'b1;
                            end else begin
                                fill_d  = fill_q - 1'b1;
                                state_d = COLLECT;
                                for (int i = 0; i < MAX_PICKS; i++) begin
                                    if (CW'(i) == fill_d) picks_d[4*i +: 4] = 4'd0;
                                end
                            end
                        end else if (key_value == KEY_OK) begin
                            if (state_q == READY) state_d = DONE;
                            else                  rej_d   = 1'b1;
                        end else if (state_q == READY || !in_range ||
                                     (ALLOW_DUP == 0 && dup)) begin
                            rej_d = 1'b1;
                        end else begin
                            for (int i = 0; i < MAX_PICKS; i++) begin
                                if (CW'(i) == fill_q) picks_d[4*i +: 4] = key_value;
                            end
                            fill_d = fill_q + 1'b1;
                            if (fill_d == target_q) state_d = READY;
                        end
                    end
                end
                default: ;
            endcase
        end

        full_d = (state_d != IDLE) && (fill_d == target_d);
        conf_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            picks_q   <= '0;
            fill_q    <= '0;
            target_q  <= '0;
            mask_q    <= '0;
            full_q    <= 1'b0;
            conf_q    <= 1'b0;
            rej_q     <= 1'b0;
            en_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            picks_q   <= picks_d;
            fill_q    <= fill_d;
            target_q  <= target_d;
            mask_q    <= mask_d;
            full_q    <= full_d;
            conf_q    <= conf_d;
            rej_q     <= rej_d;
            en_prev_q <= enable;
        end
    end

    assign picks      = picks_q;
    assign fill_count = fill_q;
    assign pick_mask  = mask_q;
    assign full       = full_q;
    assign confirmed  = conf_q;
    assign reject     = rej_q;

endmodule

// File: tb/tb_bet_pick_collector.sv
// Directed bench for bet_pick_collector (default parameters) with a queue of expected outputs.
module tb_bet_pick_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear;
    logic        key_valid;
    logic [3:0]  key_value;
    logic [2:0]  pick_req;
    logic [15:0] picks;
    logic [2:0]  fill_count;
    logic [7:0]  pick_mask;
    logic        full;
    logic        confirmed;
    logic        reject;

    typedef struct packed {
        logic [15:0] picks;
        logic [2:0]  fill;
        logic [7:0]  mask;
        logic        full;
        logic        conf;
        logic        rej;
    } exp_t;

    exp_t  sbq[$];
    string tagq[$];
    int    checks = 0;
    int    errors = 0;

    bet_pick_collector dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .clear      (clear),
        .key_valid  (key_valid),
        .key_value  (key_value),
        .pick_req   (pick_req),
        .picks      (picks),
        .fill_count (fill_count),
        .pick_mask  (pick_mask),
        .full       (full),
        .confirmed  (confirmed),
        .reject     (reject)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [15:0] p, input logic [2:0] f,
                        input logic [7:0] m, input logic fl, input logic cf, input logic rj);
        exp_t e;
        e.picks = p; e.fill = f; e.mask = m; e.full = fl; e.conf = cf; e.rej = rj;
        sbq.push_back(e);
        tagq.push_back(tag);
    endtask

    task automatic compare_front();
        exp_t  e;
        string t;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sbq.pop_front();
        t = tagq.pop_front();
        chk({t, ".picks"}, 32'(picks),      32'(e.picks));
        chk({t, ".fill"},  32'(fill_count), 32'(e.fill));
        chk({t, ".mask"},  32'(pick_mask),  32'(e.mask));
        chk({t, ".full"},  32'(full),       32'(e.full));
        chk({t, ".conf"},  32'(confirmed),  32'(e.conf));
        chk({t, ".rej"},   32'(reject),     32'(e.rej));
    endtask

    // Drive one cycle of inputs, record what the outputs must be after the edge, then compare.
    task automatic step(input string tag, input logic kv, input logic [3:0] k,
                        input logic [15:0] p, input logic [2:0] f, input logic [7:0] m,
                        input logic fl, input logic cf, input logic rj);
        key_valid = kv;
        key_value = k;
        push(tag, p, f, m, fl, cf, rj);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_value = 4'd0;
        compare_front();
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; clear = 1'b0;
        key_valid = 1'b0; key_value = 4'd0; pick_req = 3'd0;
        #1;
        push("reset", 16'h0, 3'd0, 8'h00, 0, 0, 0);
        compare_front();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        step("idle", 0, 4'd0, 16'h0, 3'd0, 8'h00, 0, 0, 0);

        // pick_req=2, keys 3,5,confirm
        pick_req = 3'd2; enable = 1'b1;
        step("A.en",   0, 4'd0,  16'h0000, 3'd0, 8'h00, 0, 0, 0);
        step("A.k3",   1, 4'd3,  16'h0003, 3'd1, 8'h04, 0, 0, 0);
        step("A.k5",   1, 4'd5,  16'h0053, 3'd2, 8'h14, 1, 0, 0);
        step("A.ok",   1, 4'd12, 16'h0053, 3'd2, 8'h14, 1, 1, 0);
        step("A.done", 1, 4'd3,  16'h0053, 3'd2, 8'h14, 1, 1, 0);
        enable = 1'b0;
        step("A.off",  0, 4'd0,  16'h0000, 3'd0, 8'h00, 0, 0, 0);

        // duplicates, early confirm, backspace to empty
        pick_req = 3'd3; enable = 1'b1;
        step("B.en",    0, 4'd0,  16'h0000, 3'd0, 8'h00, 0, 0, 0);
        step("B.k4",    1, 4'd4,  16'h0004, 3'd1, 8'h08, 0, 0, 0);
        step("B.dup",   1, 4'd4,  16'h0004, 3'd1, 8'h08, 0, 0, 1);
        step("B.okcol", 1, 4'd12, 16'h0004, 3'd1, 8'h08, 0, 0, 1);
        step("B.bksp",  1, 4'd10, 16'h0000, 3'd0, 8'h00, 0, 0, 0);
        step("B.bkemp", 1, 4'd10, 16'h0000, 3'd0, 8'h00, 0, 0, 1);
        enable = 1'b0;
        step("B.off",   0, 4'd0,  16'h0000, 3'd0, 8'h00, 0, 0, 0);

        // pick_req=1, keys 9,2,6,bksp,6,confirm
        pick_req = 3'd1; enable = 1'b1;
        step("C.en",   0, 4'd0,  16'h0000, 3'd0, 8'h00, 0, 0, 0);
        step("C.k9",   1, 4'd9,  16'h0000, 3'd0, 8'h00, 0, 0, 1);
        step("C.k2",   1, 4'd2,  16'h0002, 3'd1, 8'h02, 1, 0, 0);
        step("C.k6r",  1, 4'd6,  16'h0002, 3'd1, 8'h02, 1, 0, 1);
        step("C.bksp", 1, 4'd10, 16'h0000, 3'd0, 8'h00, 0, 0, 0);
        step("C.k6",   1, 4'd6,  16'h0006, 3'd1, 8'h20, 1, 0, 0);
        step("C.ok",   1, 4'd12, 16'h0006, 3'd1, 8'h20, 1, 1, 0);
        enable = 1'b0;
        step("C.off",  0, 4'd0,  16'h0000, 3'd0, 8'h00, 0, 0, 0);

        // pick_req=7 saturates to 4; later pick_req change must not matter
        pick_req = 3'd7; enable = 1'b1;
        step("D.en",  0, 4'd0,  16'h0000, 3'd0, 8'h00, 0, 0, 0);
        pick_req = 3'd1;
        step("D.k1",  1, 4'd1,  16'h0001, 3'd1, 8'h01, 0, 0, 0);
        step("D.k2",  1, 4'd2,  16'h0021, 3'd2, 8'h03, 0, 0, 0);
        step("D.k3",  1, 4'd3,  16'h0321, 3'd3, 8'h07, 0, 0, 0);
        step("D.k4",  1, 4'd4,  16'h4321, 3'd4, 8'h0F, 1, 0, 0);
        step("D.clr", 1, 4'd11, 16'h0000, 3'd0, 8'h00, 0, 0, 0);
        step("D.k8",  1, 4'd8,  16'h0008, 3'd1, 8'h80, 0, 0, 0);

        // clear beats a simultaneous key; keys in IDLE are ignored
        clear = 1'b1;
        step("E.clrkey", 1, 4'd5, 16'h0000, 3'd0, 8'h00, 0, 0, 0);
        clear = 1'b0;
        step("E.idlekey", 1, 4'd5, 16'h0000, 3'd0, 8'h00, 0, 0, 0);
        enable = 1'b0;
        step("E.off", 0, 4'd0, 16'h0000, 3'd0, 8'h00, 0, 0, 0);

        // async reset mid-COLLECT
        pick_req = 3'd3; enable = 1'b1;
        step("F.en", 0, 4'd0, 16'h0000, 3'd0, 8'h00, 0, 0, 0);
        step("F.k1", 1, 4'd1, 16'h0001, 3'd1, 8'h01, 0, 0, 0);
        step("F.k2", 1, 4'd2, 16'h0021, 3'd2, 8'h03, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        push("F.async", 16'h0000, 3'd0, 8'h00, 0, 0, 0);
        compare_front();
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("F.off", 0, 4'd0, 16'h0000, 3'd0, 8'h00, 0, 0, 0);
        enable = 1'b1;
        step("F.en2", 0, 4'd0, 16'h0000, 3'd0, 8'h00, 0, 0, 0);
        step("F.k7",  1, 4'd7, 16'h0007, 3'd1, 8'h40, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bet_pick_collector.md
BET_PICK_COLLECTOR -- requirements
Module: bet_pick_collector

Interface
REQ-001 The block SHALL have parameter MAX_PICKS, default 4, meaning number of pick slots.
REQ-002 The block SHALL have parameter NUM_MIN, default 1, meaning lowest legal roulette number key.
REQ-003 The block SHALL have parameter NUM_MAX, default 8, meaning highest legal roulette number key (≤ 9).
REQ-004 The block SHALL have parameter ALLOW_DUP, default 0, meaning 1 accepts repeated numbers.
REQ-005 The block SHALL have one clock, clk (input, 1), with all state updated on its rising edge.
REQ-006 The block SHALL have rst (input, 1), the asynchronous, active-low reset.
REQ-007 The block SHALL have enable (input, 1), meaning number-input phase active.
REQ-008 The block SHALL have clear (input, 1), meaning synchronous round reset.
REQ-009 The block SHALL have key_valid (input, 1), a one-cycle key strobe.
REQ-010 The block SHALL have key_value (input, 4), the key code: 1-9 digits, 10 backspace, 11 clear-all, 12 confirm.
REQ-011 The block SHALL have pick_req (input, clog2(MAX_PICKS+1)), meaning required pick count.
REQ-012 The block SHALL have picks (output, MAX_PICKS*4), with slot i at bits [4i+3:4i] and unused slots at 0.
REQ-013 The block SHALL have fill_count (output, clog2(MAX_PICKS+1)), the number of slots filled.
REQ-014 The block SHALL have pick_mask (output, NUM_MAX), where bit n-1 set means number n is chosen.
REQ-015 The block SHALL have full (output, 1), asserted when fill_count equals the latched target.
REQ-016 The block SHALL have confirmed (output, 1), a level that stays high until the block leaves DONE.
REQ-017 The block SHALL have reject (output, 1), a one-cycle pulse on an illegal key.

Function
REQ-018 The block SHALL implement states IDLE, COLLECT, READY, DONE.
REQ-019 On enable going 0→1 in IDLE, the block SHALL latch target = pick_req saturated to [1, MAX_PICKS], empty all slots and enter COLLECT.
REQ-020 In COLLECT, a digit in [NUM_MIN, NUM_MAX] SHALL be written to slot fill_count and increment fill_count, provided ALLOW_DUP=1 or its pick_mask bit is clear.
REQ-021 When fill_count reaches target, the block SHALL enter READY.
REQ-022 Backspace SHALL zero the last slot, clear its mask bit (unless another slot holds it) and decrement fill_count; in READY it SHALL also return the block to COLLECT.
REQ-023 Clear-all (11) SHALL empty all slots and enter COLLECT from COLLECT or READY.
REQ-024 Confirm (12) in READY SHALL enter DONE and set confirmed.
REQ-025 In DONE, all keys SHALL be ignored with no reject.
REQ-026 reject SHALL pulse for: an out-of-range digit, a duplicate with ALLOW_DUP=0, a digit while READY, confirm while in COLLECT, and backspace when empty.
REQ-027 All outputs SHALL be registered, reflecting a key on the cycle after key_valid with one-cycle latency.
REQ-028 clear=1 SHALL force IDLE, zero all slots and outputs, and take priority over a simultaneous key_valid.
REQ-029 enable=0 in any state SHALL force IDLE and zero all outputs on the next edge.
REQ-030 Changes to pick_req after latching SHALL be ignored until the next IDLE→COLLECT transition.
REQ-031 key_valid while in IDLE SHALL be ignored.

Reset
REQ-032 Asserting rst low SHALL immediately force IDLE with all slots 0, fill_count 0, pick_mask 0, and full, confirmed, reject at 0.
REQ-033 Deasserting rst SHALL be followed by normal operation from the first rising clk edge.

Structure
REQ-034 Key codes (KEY_BKSP=10, KEY_CLR=11, KEY_OK=12) and the state encoding SHALL live in the shared package roulette_pkg.
REQ-035 The mask/duplicate logic SHALL be one combinational sub-module pick_mask_gen (slots in, NUM_MAX mask out).

Verification
REQ-036 Scenario: pick_req=2, keys 3,5,12 → picks[7:0]=0x53, pick_mask=0x14, full=1, confirmed=1.
REQ-037 Scenario: pick_req=3, ALLOW_DUP=0, keys 4,4 → second key gives reject pulse and fill_count stays 1.
REQ-038 Scenario: pick_req=1, keys 9, 2, 6, 10, 6, 12 → reject on 9 and the first 6; final picks slot0=6, confirmed=1.
REQ-039 Scenario: pick_req=7 with MAX_PICKS=4 → target saturates to 4, and full asserts after the 4th legal digit.
REQ-040 Scenario: clear and key_valid(5) in the same cycle → IDLE with all outputs 0 and no slot written.
REQ-041 Scenario: async rst low mid-COLLECT with fill_count=2 → outputs zero without a clock edge, and the block re-enters COLLECT on the next enable rise.
